// File: rtl/mant_addsub_seq_if.sv
// mant_addsub_seq_if -- request/result bundle for mant_addsub_seq.
//   start, op, A, B, Ci : request side (master drives)
//   busy, done, F, Co, Neg : status/result side (slave drives)
// The WIDTH parameter must match the WIDTH of the attached mant_addsub_seq.
interface mant_addsub_seq_if #(
    parameter int WIDTH = 24
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] F;
    logic             Co;
    logic             Neg;

    modport master (
        output start, op, A, B, Ci,
        input  busy, done, F, Co, Neg
    );

    modport slave (
        input  start, op, A, B, Ci,
        output busy, done, F, Co, Neg
    );
endinterface

// File: rtl/mant_addsub_seq.sv
// mant_addsub_seq -- sequential add/subtract that walks the operands CHUNK
// bits per clock, LSB chunk first, rippling carry/borrow between chunks.
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : mant_addsub_seq_if.slave
//          start/op/A/B/Ci request (sampled only while not busy),
//          busy (RUN/NEG), done (one-cycle pulse), F/Co/Neg registered result
// Optional feature: define MANT_ADDSUB_ABS_EN to return the magnitude of a
// negative difference (extra NEG cycle, Neg=1). Without it Neg is tied 0.
// WIDTH must be an integer multiple of CHUNK.
module mant_addsub_seq #(
    parameter int WIDTH = 24,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    mant_addsub_seq_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;     // partial result, never exported directly
    logic [WIDTH-1:0] f_q, f_d;
    logic             op_q, op_d;
    logic             cy_q, cy_d;       // carry (add) or borrow (sub) into current chunk
    logic             co_q, co_d;
    logic [IW-1:0]    idx_q, idx_d;
`ifdef MANT_ADDSUB_ABS_EN
    logic             neg_q, neg_d;
`endif

    logic [CHUNK-1:0] a_c, b_c;
    logic [CHUNK:0]   t;
    logic [WIDTH-1:0] raw;
    int               base;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        f_d     = f_q;
        op_d    = op_q;
        cy_d    = cy_q;
        co_d    = co_q;
        idx_d   = idx_q;
`ifdef MANT_ADDSUB_ABS_EN
        neg_d   = neg_q;
`endif

        base = int'(idx_q) * CHUNK;
        a_c  = a_q[base +: CHUNK];
        b_c  = b_q[base +: CHUNK];
        // Bit CHUNK of the (CHUNK+1)-bit add/sub is the carry or borrow out.
        if (!op_q)
            t = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, cy_q};
        else
            t = {1'b0, a_c} - {1'b0, b_c} - {{CHUNK{1'b0}}, cy_q};
        raw = res_q;
        raw[base +: CHUNK] = t[CHUNK-1:0];

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = bus.op;
                    cy_d    = bus.Ci;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d = raw;
                cy_d  = t[CHUNK];
                if (idx_q == LAST) begin
`ifdef MANT_ADDSUB_ABS_EN
                    if (op_q && t[CHUNK]) begin
                        state_d = NEG;
                    end else begin
                        f_d     = raw;
                        co_d    = t[CHUNK];
                        neg_d   = 1'b0;
                        state_d = DONE;
                    end
`else
                    f_d     = raw;
                    co_d    = t[CHUNK];
                    state_d = DONE;
`endif
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
`ifdef MANT_ADDSUB_ABS_EN
            NEG: begin
                // Raw difference wrapped negative; publish its magnitude.
                f_d     = '0 - res_q;
                co_d    = 1'b1;
                neg_d   = 1'b1;
                state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            f_q     <= '0;
            op_q    <= 1'b0;
            cy_q    <= 1'b0;
            co_q    <= 1'b0;
            idx_q   <= '0;
`ifdef MANT_ADDSUB_ABS_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            f_q     <= f_d;
            op_q    <= op_d;
            cy_q    <= cy_d;
            co_q    <= co_d;
            idx_q   <= idx_d;
`ifdef MANT_ADDSUB_ABS_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN) || (state_q == NEG);
    assign bus.done = (state_q == DONE);
    assign bus.F    = f_q;
    assign bus.Co   = co_q;
`ifdef MANT_ADDSUB_ABS_EN
    assign bus.Neg  = neg_q;
`else
    assign bus.Neg  = 1'b0;
`endif
endmodule

// File: tb/tb_mant_addsub_seq.sv
// Directed bench for mant_addsub_seq: a 24-bit/4-bit-chunk instance and an
// 8-bit single-chunk instance, with hand-computed expectations.
module tb_mant_addsub_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mant_addsub_seq_if #(.WIDTH(24)) if24();
    mant_addsub_seq_if #(.WIDTH(8))  if8();

    mant_addsub_seq #(.WIDTH(24), .CHUNK(4)) u24 (.clk(clk), .rst(rst), .bus(if24));
    mant_addsub_seq #(.WIDTH(8),  .CHUNK(8)) u8  (.clk(clk), .rst(rst), .bus(if8));

    int n_chk  = 0;
    int n_fail = 0;

`ifdef MANT_ADDSUB_ABS_EN
    localparam bit ABS = 1'b1;
`else
    localparam bit ABS = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one 24-bit op, watch 10 cycles; report latency and done count.
    // With noise set, extra start pulses with other operands land at cycles 2 and 4.
    task automatic run24(input string tag, input logic op, input logic [23:0] a, input logic [23:0] b,
                         input logic ci, input bit noise, output int lat, output int ndone);
        logic [23:0] prev_f;
        @(negedge clk);
        prev_f    = if24.F;
        if24.start = 1'b1; if24.op = op; if24.A = a; if24.B = b; if24.Ci = ci;
        @(negedge clk);
        if24.start = 1'b0;
        lat = 0; ndone = 0;
        for (int c = 1; c <= 10; c++) begin
            if (noise && (c == 2 || c == 4)) begin
                if24.start = 1'b1; if24.A = 24'hFFFFFF; if24.B = 24'hFFFFFF; if24.op = ~op;
            end else begin
                if24.start = 1'b0;
            end
            if (c == 3) begin
                chk({tag, "_busy"}, {31'd0, if24.busy}, 32'd1);
                chk({tag, "_F_hold"}, {8'd0, if24.F}, {8'd0, prev_f});
            end
            @(negedge clk);
            if (if24.done) begin
                ndone++;
                if (lat == 0) lat = c;
            end
        end
        if24.start = 1'b0;
    endtask

    task automatic res24(input string tag, input logic [23:0] f, input logic co, input logic neg, input int lat_exp,
                         input int lat, input int ndone);
        chk({tag, "_F"},    {8'd0, if24.F}, {8'd0, f});
        chk({tag, "_Co"},   {31'd0, if24.Co}, {31'd0, co});
        chk({tag, "_Neg"},  {31'd0, if24.Neg}, {31'd0, neg});
        chk({tag, "_lat"},  lat, lat_exp);
        chk({tag, "_ndone"}, ndone, 1);
    endtask

    int lat, nd;

    initial begin
        rst = 1'b1;
        if24.start = 0; if24.op = 0; if24.A = '0; if24.B = '0; if24.Ci = 0;
        if8.start  = 0; if8.op  = 0; if8.A  = '0; if8.B  = '0; if8.Ci  = 0;
        repeat (2) @(negedge clk);
        chk("rst24_busy", {31'd0, if24.busy}, 32'd0);
        chk("rst24_done", {31'd0, if24.done}, 32'd0);
        chk("rst24_F",    {8'd0, if24.F}, 32'd0);
        chk("rst24_Co",   {31'd0, if24.Co}, 32'd0);
        chk("rst24_Neg",  {31'd0, if24.Neg}, 32'd0);
        chk("rst8_F",     {24'd0, if8.F}, 32'd0);
        chk("rst8_done",  {31'd0, if8.done}, 32'd0);
        rst = 1'b0;

        // 0x10 - 0x01
        run24("sub_pos", 1'b1, 24'h000010, 24'h000001, 1'b0, 1'b0, lat, nd);
        res24("sub_pos", 24'h00000F, 1'b0, 1'b0, 6, lat, nd);

        // 0 - 1: wraps, or magnitude with the ABS feature
        run24("sub_neg", 1'b1, 24'h000000, 24'h000001, 1'b0, 1'b0, lat, nd);
        if (ABS) res24("sub_neg", 24'h000001, 1'b1, 1'b1, 7, lat, nd);
        else     res24("sub_neg", 24'hFFFFFF, 1'b1, 1'b0, 6, lat, nd);

        // Full carry ripple
        run24("add_ripple", 1'b0, 24'hFFFFFF, 24'h000001, 1'b0, 1'b0, lat, nd);
        res24("add_ripple", 24'h000000, 1'b1, 1'b0, 6, lat, nd);

        // Carry-in on add
        run24("add_ci", 1'b0, 24'h123456, 24'h654321, 1'b1, 1'b0, lat, nd);
        res24("add_ci", 24'h777778, 1'b0, 1'b0, 6, lat, nd);
        chk("hold_F_later", {8'd0, if24.F}, 32'h00777778);
        chk("done_low_later", {31'd0, if24.done}, 32'd0);

        // Borrow-in on sub: 5 - 5 - 1 = -1
        run24("sub_bi", 1'b1, 24'h000005, 24'h000005, 1'b1, 1'b0, lat, nd);
        if (ABS) res24("sub_bi", 24'h000001, 1'b1, 1'b1, 7, lat, nd);
        else     res24("sub_bi", 24'hFFFFFF, 1'b1, 1'b0, 6, lat, nd);

        // Start while busy is ignored
        run24("noise", 1'b0, 24'h000100, 24'h000200, 1'b0, 1'b1, lat, nd);
        res24("noise", 24'h000300, 1'b0, 1'b0, 6, lat, nd);

        // Reset at cycle 3 of RUN abandons the op
        @(negedge clk);
        if24.start = 1'b1; if24.op = 1'b1; if24.A = 24'h000050; if24.B = 24'h000020; if24.Ci = 1'b0;
        @(negedge clk);
        if24.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, if24.busy}, 32'd0);
        chk("midrst_done", {31'd0, if24.done}, 32'd0);
        chk("midrst_F",    {8'd0, if24.F}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (if24.done) nd++;
        end
        chk("midrst_nodone", nd, 0);
        run24("after_rst", 1'b0, 24'h000003, 24'h000004, 1'b0, 1'b0, lat, nd);
        res24("after_rst", 24'h000007, 1'b0, 1'b0, 6, lat, nd);

        // Single-chunk instance: 0x80 - 0x01 - 1
        @(negedge clk);
        if8.start = 1'b1; if8.op = 1'b1; if8.A = 8'h80; if8.B = 8'h01; if8.Ci = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        chk("n1_busy", {31'd0, if8.busy}, 32'd1);
        chk("n1_notyet", {31'd0, if8.done}, 32'd0);
        @(negedge clk);
        chk("n1_done", {31'd0, if8.done}, 32'd1);
        chk("n1_F",    {24'd0, if8.F}, 32'h7E);
        chk("n1_Co",   {31'd0, if8.Co}, 32'd0);
        chk("n1_Neg",  {31'd0, if8.Neg}, 32'd0);
        @(negedge clk);
        chk("n1_done_pulse", {31'd0, if8.done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mant_addsub_seq.md
MANT_ADDSUB_SEQ -- requirements
Module: mant_addsub_seq

Interface
REQ-001 Parameter: WIDTH, 24, operand/result width in bits.
REQ-002 Parameter: CHUNK, 4, bits processed per clock; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request; sampled only when busy=0.
REQ-006 Port: op  input  1  0 = add, 1 = subtract.
REQ-007 Port: A  input  WIDTH  minuend/addend.
REQ-008 Port: B  input  WIDTH  subtrahend/addend.
REQ-009 Port: Ci  input  1  carry-in (add) / borrow-in (sub).
REQ-010 Port: busy  output  1  high while an operation is in progress.
REQ-011 Port: done  output  1  one-cycle pulse: F/Co/Neg updated.
REQ-012 Port: F  output  WIDTH  registered result.
REQ-013 Port: Co  output  1  carry-out (add) / borrow-out (sub).
REQ-014 Port: Neg  output  1  result-negated flag (see Configuration).

Function
REQ-015 States SHALL be IDLE, RUN, NEG, DONE; busy=1 in RUN and NEG only.
REQ-016 IDLE or DONE with start=1 at an edge SHALL latch A, B, Ci, op, clear the chunk index, and go to RUN.
REQ-017 start while busy=1 SHALL be ignored; latched operands SHALL not change.
REQ-018 RUN SHALL process one CHUNK per edge, LSB chunk first; the carry/borrow of each chunk SHALL feed the next.
REQ-019 After the edge processing chunk N-1, state SHALL go to DONE (or NEG per REQ-030); index SHALL not wrap or run beyond N-1.
REQ-020 Add: F = (A + B + Ci) mod 2^WIDTH; Co = bit WIDTH of A + B + Ci.
REQ-021 Sub: F = (A - B - Ci) mod 2^WIDTH; Co = 1 iff A < B + Ci (unsigned).
REQ-022 F, Co, Neg SHALL update only on the edge entering DONE and SHALL hold until the next completion or reset; partial results SHALL not be visible.
REQ-023 done SHALL be 1 exactly during the DONE cycle; DONE -> IDLE on the next edge unless start=1 (REQ-016).
REQ-024 Latency: done high N cycles after the start-sampling edge (N+1 when the NEG state is visited).
REQ-025 N = 1 (CHUNK = WIDTH) SHALL be supported: one RUN cycle.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, F=0, Co=0, Neg=0, busy=0, done=0, and chunk index 0, regardless of clk.
REQ-027 rst asserted mid-operation SHALL abandon it without a done pulse; the first start after rst deasserts SHALL run normally.
REQ-028 Latched operand registers SHALL reset to 0.

Configuration
REQ-029 Macro MANT_ADDSUB_ABS_EN SHALL select magnitude output for subtraction.
REQ-030 Defined: on op=1 with final borrow=1, RUN SHALL go to NEG for one cycle; the NEG edge SHALL write F = two's complement of the raw difference (mod 2^WIDTH), Co=1, Neg=1; otherwise Neg=0.
REQ-031 Not defined: NEG SHALL never be entered, F SHALL be the raw wrapped difference, and Neg SHALL be tied 0; port list unchanged.

Verification
REQ-032 WIDTH=24, CHUNK=4, sub A=0x000010, B=0x000001, Ci=0 -> F=0x00000F, Co=0, Neg=0, done 6 cycles after start.
REQ-033 Sub A=0x000000, B=0x000001, Ci=0 -> without macro F=0xFFFFFF, Co=1, done at 6; with macro F=0x000001, Co=1, Neg=1, done at 7.
REQ-034 Add A=0xFFFFFF, B=0x000001, Ci=0 -> F=0x000000, Co=1 (carry through all 6 chunks).
REQ-035 Start, then start pulses with different A/B at cycles 2 and 4 -> ignored; result matches the first operands; single done pulse.
REQ-036 rst asserted at cycle 3 of RUN -> busy=0, F=0, no done; new start of add 0x000003+0x000004 -> F=0x000007 at cycle 6.
REQ-037 WIDTH=8, CHUNK=8, sub A=0x80, B=0x01, Ci=1 -> F=0x7E, Co=0, done 1 cycle after start.
